// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider: (QW+DW)-bit dividend / DW-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider #(
    parameter int QW = 11,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [QW+DW-1:0] dividend,
    input  logic [DW-1:0]    divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW-1:0]    quotient,
    output logic [DW-1:0]    remainder,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int CW = $clog2(QW);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;

    logic [QW-1:0] dvd_q, q_q;
    logic [DW-1:0] dvs_q, rem_q;
    logic [CW-1:0] cnt_q;
    logic          dbz_q, ovf_q;

    logic          accept, err, t_ge;
    logic [DW-1:0] hi, t_sub;
    logic [DW:0]   t;

    assign accept = in_valid && in_ready;
    assign hi     = dividend[QW+DW-1:QW];
    assign err    = dbz_q | ovf_q;
    // dividend bits are consumed MSB first by shifting dvd_q left
    assign t      = {rem_q, dvd_q[QW-1]};
    assign t_ge   = t >= {1'b0, dvs_q};
    // difference is below the divisor, so modular DW-bit subtraction is exact
    assign t_sub  = t[DW-1:0] - dvs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)         state_nx = CALC;
            CALC:    if (cnt_q == '0)    state_nx = DONE;
            DONE:    if (out_ready)      state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    // Error cases still pass through one CALC cycle (counter preset to 0) so
    // their results appear one cycle after accept; arithmetic is skipped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvd_q <= '0;
            dvs_q <= '0;
            q_q   <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            dvd_q <= dividend[QW-1:0];
            dvs_q <= divisor;
            if (divisor == '0) begin
                dbz_q <= 1'b1;
                ovf_q <= 1'b0;
                q_q   <= '1;
                rem_q <= dividend[DW-1:0];
                cnt_q <= '0;
            end else if (hi >= divisor) begin
                dbz_q <= 1'b0;
                ovf_q <= 1'b1;
                q_q   <= '1;
                rem_q <= '0;
                cnt_q <= '0;
            end else begin
                dbz_q <= 1'b0;
                ovf_q <= 1'b0;
                q_q   <= '0;
                rem_q <= hi;
                cnt_q <= CW'(QW - 1);
            end
        end else if (state == CALC) begin
            if (!err) begin
                rem_q <= t_ge ? t_sub : t[DW-1:0];
                q_q   <= {q_q[QW-2:0], t_ge};
                dvd_q <= {dvd_q[QW-2:0], 1'b0};
            end
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = q_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider: latency, results, error flags,
// output stall, input blocking while busy, and mid-operation reset.
module tb_seq_restoring_divider;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [18:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid, out_ready;
    logic [10:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero, overflow;

    int checks = 0;
    int failures = 0;

    seq_restoring_divider #(.QW(11), .DW(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Present an operation, wait for acceptance, then count edges to out_valid.
    // lat = -1 if never accepted, 60 if out_valid never arrived.
    task automatic run_op(input logic [18:0] z, input logic [7:0] x, output int lat);
        logic acc;
        int   g;
        @(negedge clk);
        dividend = z; divisor = x; in_valid = 1'b1;
        acc = 1'b0; g = 0;
        while (!acc && g < 60) begin
            acc = in_ready;
            @(posedge clk); #1;
            g++;
        end
        in_valid = 1'b0;
        lat = 0;
        if (!acc) lat = -1;
        else while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        dividend = '0; divisor = '0;
        #22;
        checks++;
        if (out_valid !== 1'b0 || quotient !== 11'd0 || remainder !== 8'd0 ||
            div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ov=%b q=%0d r=%0d dz=%b of=%b, want all 0",
                     out_valid, quotient, remainder, div_by_zero, overflow);
        end
        @(negedge clk); reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic(input logic [18:0] z, input logic [7:0] x,
                              input logic [10:0] eq, input logic [7:0] er, input int elat);
        int lat;
        run_op(z, x, lat);
        checks++;
        if (lat !== elat) begin
            failures++;
            $display("FAIL basic_latency %0d/%0d: got %0d want %0d", z, x, lat, elat);
        end
        checks++;
        if (quotient !== eq || remainder !== er || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL basic_result %0d/%0d: q=%0d r=%0d dz=%b of=%b want q=%0d r=%0d flags 0",
                     z, x, quotient, remainder, div_by_zero, overflow, eq, er);
        end
    endtask

    task automatic test_errors;
        int lat;
        run_op(19'd6144, 8'd3, lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL overflow_latency: got %0d want 1", lat);
        end
        checks++;
        if (overflow !== 1'b1 || div_by_zero !== 1'b0 || quotient !== 11'd2047 || remainder !== 8'd0) begin
            failures++;
            $display("FAIL overflow_result: of=%b dz=%b q=%0d r=%0d want 1 0 2047 0",
                     overflow, div_by_zero, quotient, remainder);
        end
        run_op(19'd12345, 8'd0, lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL divzero_latency: got %0d want 1", lat);
        end
        checks++;
        if (div_by_zero !== 1'b1 || overflow !== 1'b0 || quotient !== 11'd2047 || remainder !== 8'h39) begin
            failures++;
            $display("FAIL divzero_result: dz=%b of=%b q=%0d r=%h want 1 0 2047 39",
                     div_by_zero, overflow, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back;
        int g, lat;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 60) begin @(negedge clk); g++; end
        dividend = 19'd1000; divisor = 8'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        repeat (3) begin @(posedge clk); #1; lat++; end
        // second request while busy must be ignored
        @(negedge clk);
        dividend = 19'd50; divisor = 8'd5; in_valid = 1'b1;
        repeat (2) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL busy_in_ready: got %b want 0", in_ready);
            end
            @(posedge clk); #1; lat++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 11) begin
            failures++;
            $display("FAIL stall_latency: got %0d want 11", lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 11'd142 || remainder !== 8'd6) begin
                failures++;
                $display("FAIL stall_hold cyc%0d: ov=%b ir=%b q=%0d r=%0d want 1 0 142 6",
                         c, out_valid, in_ready, quotient, remainder);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 11'd142 || remainder !== 8'd6) begin
            failures++;
            $display("FAIL release: ir=%b ov=%b q=%0d r=%0d want 1 0 142 6",
                     in_ready, out_valid, quotient, remainder);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || quotient !== 11'd142) begin
            failures++;
            $display("FAIL not_consumed: ov=%b q=%0d want 0 142", out_valid, quotient);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_mid_reset;
        int lat;
        @(negedge clk);
        dividend = 19'd500; divisor = 8'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        in_valid = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || quotient !== 11'd0 || remainder !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset: ov=%b q=%0d r=%0d want 0 0 0", out_valid, quotient, remainder);
        end
        // in_valid held across release: taken on the first active edge
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 11 || quotient !== 11'd55 || remainder !== 8'd5 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL after_reset: lat=%0d q=%0d r=%0d dz=%b of=%b want 11 55 5 0 0",
                     lat, quotient, remainder, div_by_zero, overflow);
        end
    endtask

    initial begin
        test_reset;
        test_basic(19'd1000,   8'd7,   11'd142,  8'd6,   11);
        test_basic(19'd522239, 8'd255, 11'd2047, 8'd254, 11);
        test_basic(19'd2047,   8'd1,   11'd2047, 8'd0,   11);
        test_basic(19'd0,      8'd200, 11'd0,    8'd0,   11);
        test_errors;
        test_back_to_back;
        test_mid_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
